// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: encodings shared by the memory controller and its clients.
//   - memory op / length encodings (also used by IF and the MEM stage)
//   - controller state encoding
//   - IO region decode constant (address bits [17:16])
//   - len_to_n(): request length code -> byte count
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_len_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] IO_REGION = 2'b11;
    localparam int         IO_LSB    = 16;

    // Length code 3 is not a legal encoding; it is treated as a word.
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises one byte/half/word client request onto a byte-wide
// RAM port (little endian), assembles load data and returns a one-cycle
// ready pulse.
//
// Ports:
//   clk_in, rst_in (async, active low), rdy_in (global enable, low = freeze)
//   memctl_op/len/addr/data  : client request (held until memctl_rdy)
//   memctl_rdy, memctl_out   : completion pulse, zero-extended load result
//   mem_din/mem_dout/mem_a/mem_wr : RAM port, read latency RAM_LAT (=1)
//   io_buffer_full           : only with MEMCTL_IO_EN defined
//
// Build option: define MEMCTL_IO_EN to throttle stores to the IO region
// (latched addr[17:16] == 2'b11) on io_buffer_full, with one bubble cycle
// after every IO byte write.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [1:0]        memctl_op,
    input  logic [1:0]        memctl_len,
    input  logic [ADDR_W-1:0] memctl_addr,
    input  logic [31:0]       memctl_data,
    output logic              memctl_rdy,
    output logic [31:0]       memctl_out,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
`ifdef MEMCTL_IO_EN
   ,input  logic              io_buffer_full
`endif
);

    generate
        if (RAM_LAT != 1) begin : g_lat_chk
            $error("mem_ctrl: only RAM_LAT == 1 is supported");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;       // bytes issued so far
    logic [2:0]        n_q, n_d;       // bytes in this request
    logic              ld_q, ld_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       asm_q, asm_d;   // load assembly, separate so memctl_out
    logic [31:0]       out_q, out_d;   // only changes when a load completes
    logic [2:0]        k_m1;
    logic [4:0]        cap_sh;
    logic              wr;
`ifdef MEMCTL_IO_EN
    logic              io_q, io_d;
    logic              bub_q, bub_d;
`endif

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        ld_d     = ld_q;
        base_d   = base_q;
        data_d   = data_q;
        asm_d    = asm_q;
        out_d    = out_q;
`ifdef MEMCTL_IO_EN
        io_d     = io_q;
        bub_d    = bub_q;
`endif
        wr       = 1'b0;
        k_m1     = k_q - 3'd1;
        cap_sh   = {k_m1[1:0], 3'b000};
        mem_a    = '0;
        mem_dout = '0;

        case (state_q)
            ST_IDLE: begin
                // Any non-NOP op is latched; only MEM_LOAD reads.
                if (rdy_in && memctl_op != MEM_NOP) begin
                    base_d  = memctl_addr;
                    data_d  = memctl_data;
                    ld_d    = (memctl_op == MEM_LOAD);
                    n_d     = len_to_n(memctl_len);
                    k_d     = 3'd0;
                    asm_d   = '0;
`ifdef MEMCTL_IO_EN
                    io_d    = (memctl_op != MEM_LOAD) &&
                              (memctl_addr[IO_LSB+1:IO_LSB] == IO_REGION);
                    bub_d   = 1'b0;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rdy_in) begin
                    if (ld_q) begin
                        // mem_din holds the byte addressed in the previous
                        // cycle; k == n is the trailing capture-only cycle.
                        if (k_q != 3'd0)
                            asm_d = asm_q | ({24'd0, mem_din} << cap_sh);
                        if (k_q == n_q) begin
                            out_d   = asm_d;
                            state_d = ST_RESP;
                        end else begin
                            k_d = k_q + 3'd1;
                        end
                    end
`ifdef MEMCTL_IO_EN
                    else if (io_q) begin
                        if (bub_q) begin
                            bub_d = 1'b0;
                            if (k_q == n_q)
                                state_d = ST_RESP;
                        end else if (!io_buffer_full) begin
                            wr    = 1'b1;
                            k_d   = k_q + 3'd1;
                            bub_d = 1'b1;
                        end
                    end
`endif
                    else begin
                        wr  = 1'b1;
                        k_d = k_q + 3'd1;
                        if (k_q == n_q - 3'd1)
                            state_d = ST_RESP;
                    end
                end

                // While frozen, a load points the RAM back at byte k-1 so
                // its data is on mem_din again when the enable returns.
                if (ld_q && k_q != 3'd0 && (!rdy_in || k_q == n_q))
                    mem_a = base_q + ADDR_W'(k_m1);
                else
                    mem_a = base_q + ADDR_W'(k_q);
                if (wr)
                    mem_dout = 8'(data_q >> {k_q[1:0], 3'b000});
            end
            ST_RESP: begin
                if (rdy_in)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_wr     = wr;
    assign memctl_rdy = (state_q == ST_RESP) && rdy_in;
    assign memctl_out = out_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            ld_q    <= 1'b0;
            base_q  <= '0;
            data_q  <= '0;
            asm_q   <= '0;
            out_q   <= '0;
`ifdef MEMCTL_IO_EN
            io_q    <= 1'b0;
            bub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            ld_q    <= ld_d;
            base_q  <= base_d;
            data_q  <= data_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
`ifdef MEMCTL_IO_EN
            io_q    <= io_d;
            bub_q   <= bub_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table of single requests against a
// byte RAM model, plus hand sequences for back-to-back, freeze, IO
// throttling and mid-access reset.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic [1:0]  memctl_op, memctl_len;
    logic [31:0] memctl_addr, memctl_data, memctl_out, mem_a;
    logic        memctl_rdy, mem_wr;
    logic [7:0]  mem_din, mem_dout;
    logic        io_full;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.ADDR_W(32), .RAM_LAT(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .memctl_op(memctl_op), .memctl_len(memctl_len),
        .memctl_addr(memctl_addr), .memctl_data(memctl_data),
        .memctl_rdy(memctl_rdy), .memctl_out(memctl_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
`ifdef MEMCTL_IO_EN
       ,.io_buffer_full(io_full)
`endif
    );

    // Byte RAM, one-cycle read latency; preload port used only under reset.
    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  din_q = 8'h00;
    logic        pre_we = 1'b0;
    logic [31:0] pre_a = '0;
    logic [7:0]  pre_d = '0;
    assign mem_din = din_q;

    always @(posedge clk_in) begin
        din_q <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr)      ram[mem_a] = mem_dout;
        else if (pre_we) ram[pre_a] = pre_d;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk_in); #1;
        pre_we = 1'b0;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_req(input string name, input logic [1:0] op, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int exp_lat, input logic [31:0] exp_out);
        int n, lat;
        logic st;
        n   = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        st  = (op == 2'd2);
        lat = 0;
        memctl_op = op; memctl_len = len; memctl_addr = addr; memctl_data = data;
        @(posedge clk_in);                       // latch edge T
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk_in);
            if (c <= n) begin
                chk($sformatf("%s_a%0d", name, c), mem_a, addr + 32'(c - 1));
                chk($sformatf("%s_wr%0d", name, c), 32'(mem_wr), 32'(st));
                if (st)
                    chk($sformatf("%s_do%0d", name, c), 32'(mem_dout),
                        (data >> (8 * (c - 1))) & 32'hFF);
            end
            if (memctl_rdy) begin
                lat = c;
                memctl_op = 2'd0;
            end
        end
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_out"}, memctl_out, exp_out);
        @(negedge clk_in);
        chk({name, "_pulse"}, 32'(memctl_rdy), 32'd0);
        @(posedge clk_in); #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        logic [31:0] out;
    } vec_t;

    vec_t vecs[8];

`ifdef MEMCTL_IO_EN
    localparam int IO_WR_C  = 5;
    localparam int IO_RDY_C = 7;
`else
    localparam int IO_WR_C  = 1;
    localparam int IO_RDY_C = 2;
`endif

    initial begin
        int first, pulses;
        logic wr_seen, rdy_seen;

        vecs[0] = '{2'd1, 2'd0 + 2'd2, 32'h0000_0100, 32'h0,         6, 32'h4433_2211};
        vecs[1] = '{2'd2, 2'd1,        32'h0000_0201, 32'h0000_ABCD, 3, 32'h4433_2211};
        vecs[2] = '{2'd1, 2'd1,        32'h0000_0201, 32'h0,         4, 32'h0000_ABCD};
        vecs[3] = '{2'd1, 2'd0,        32'h0000_0007, 32'h0,         3, 32'h0000_0080};
        vecs[4] = '{2'd2, 2'd2,        32'h0000_0400, 32'h0BAD_F00D, 5, 32'h0000_0080};
        vecs[5] = '{2'd1, 2'd2,        32'h0000_0400, 32'h0,         6, 32'h0BAD_F00D};
        vecs[6] = '{2'd1, 2'd2,        32'hFFFF_FFFE, 32'h0,         6, 32'hD4C3_B2A1};
        vecs[7] = '{2'd1, 2'd3,        32'h0000_0100, 32'h0,         6, 32'h4433_2211};

        rst_in = 1'b0; rdy_in = 1'b1; io_full = 1'b0;
        memctl_op = 2'd0; memctl_len = 2'd0; memctl_addr = '0; memctl_data = '0;
        repeat (2) @(posedge clk_in);
        #1;
        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        poke(32'h7, 8'h80);
        poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2);
        poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);

        @(negedge clk_in);
        chk("rst_rdy",  32'(memctl_rdy), 32'd0);
        chk("rst_out",  memctl_out, 32'd0);
        chk("rst_dout", 32'(mem_dout), 32'd0);
        chk("rst_a",    mem_a, 32'd0);
        chk("rst_wr",   32'(mem_wr), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;

        for (int i = 0; i < 8; i++)
            run_req($sformatf("v%0d", i), vecs[i].op, vecs[i].len, vecs[i].addr,
                    vecs[i].data, vecs[i].lat, vecs[i].out);

        // Back-to-back: op held high is re-accepted after RESP, not in it.
        memctl_op = 2'd1; memctl_len = 2'd0; memctl_addr = 32'h7;
        @(posedge clk_in);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_in);
            chk($sformatf("b2b_rdy%0d", c), 32'(memctl_rdy), 32'((c == 3) || (c == 7)));
            if (c == 4) chk("b2b_idle_a", mem_a, 32'h0);
            if (c == 5) chk("b2b_run_a",  mem_a, 32'h7);
            if (c == 7) memctl_op = 2'd0;
        end
        chk("b2b_out", memctl_out, 32'h80);
        @(negedge clk_in);
        chk("b2b_pulse", 32'(memctl_rdy), 32'd0);
        @(posedge clk_in); #1;

        // Freeze for cycles T+2..T+4 of a word load.
        memctl_op = 2'd1; memctl_len = 2'd2; memctl_addr = 32'h100;
        first = 0; pulses = 0; wr_seen = 1'b0;
        @(posedge clk_in);
        for (int c = 1; c <= 14; c++) begin
            #1 rdy_in = !(c >= 2 && c <= 4);
            @(negedge clk_in);
            if (mem_wr) wr_seen = 1'b1;
            if (memctl_rdy) begin
                pulses++;
                if (first == 0) first = c;
                memctl_op = 2'd0;
            end
            @(posedge clk_in);
        end
        #1 rdy_in = 1'b1;
        chk("frz_lat",    32'(first), 32'd9);
        chk("frz_pulses", 32'(pulses), 32'd1);
        chk("frz_wr",     32'(wr_seen), 32'd0);
        chk("frz_out",    memctl_out, 32'h4433_2211);

        // IO region store; throttled only when the IO option is built in.
        memctl_op = 2'd2; memctl_len = 2'd0; memctl_addr = 32'h0003_0000; memctl_data = 32'h41;
        io_full = 1'b1; first = 0;
        @(posedge clk_in);
        for (int c = 1; c <= 10; c++) begin
            #1 io_full = (c <= 4);
            @(negedge clk_in);
            if (c <= IO_RDY_C)
                chk($sformatf("io_wr%0d", c), 32'(mem_wr), 32'(c == IO_WR_C));
            if (c == IO_WR_C) begin
                chk("io_a",    mem_a, 32'h0003_0000);
                chk("io_dout", 32'(mem_dout), 32'h41);
            end
            if (memctl_rdy && first == 0) begin
                first = c;
                memctl_op = 2'd0;
            end
            @(posedge clk_in);
        end
        #1 io_full = 1'b0;
        chk("io_lat", 32'(first), 32'(IO_RDY_C));

        // Reset in the middle of a word store.
        memctl_op = 2'd2; memctl_len = 2'd2; memctl_addr = 32'h500; memctl_data = 32'h1122_3344;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("mr_wr1", 32'(mem_wr), 32'd1);
        chk("mr_a1",  mem_a, 32'h500);
        @(posedge clk_in); #2;
        rst_in = 1'b0; memctl_op = 2'd0;
        #1;
        chk("mr_wr",   32'(mem_wr), 32'd0);
        chk("mr_a",    mem_a, 32'd0);
        chk("mr_dout", 32'(mem_dout), 32'd0);
        chk("mr_rdy",  32'(memctl_rdy), 32'd0);
        chk("mr_out",  memctl_out, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        rdy_seen = 1'b0;
        repeat (6) begin
            @(negedge clk_in);
            if (memctl_rdy) rdy_seen = 1'b1;
        end
        chk("mr_no_rdy", 32'(rdy_seen), 32'd0);
        chk("mr_byte0",  32'(ram[32'h500]), 32'h44);
        chk("mr_byte1",  32'(ram.exists(32'h501)), 32'd0);
        @(posedge clk_in); #1;
        run_req("mr_load", 2'd1, 2'd2, 32'h100, 32'h0, 6, 32'h4433_2211);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
